// File: rtl/riscv_exec_unit_if.sv
// Operation codes shared by the execute unit and its users, plus the request/response
// bus that groups the execute unit's handshake and data signals.
package riscv_constants_pkg;
    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SLL    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_SLT    = 5'd8,
        ALU_SLTU   = 5'd9,
        ALU_COPY1  = 5'd10,
        ALU_MUL    = 5'd11,
        ALU_MULH   = 5'd12,
        ALU_MULHSU = 5'd13,
        ALU_MULHU  = 5'd14,
        ALU_DIV    = 5'd15,
        ALU_DIVU   = 5'd16,
        ALU_REM    = 5'd17,
        ALU_REMU   = 5'd18
    } EXEC_FUN;
endpackage

interface riscv_exec_unit_if #(parameter int unsigned WORD_LENGTH = 32);
    import riscv_constants_pkg::*;

    logic                   req_valid;
    logic                   req_ready;
    EXEC_FUN                exec_fun;
    logic [WORD_LENGTH-1:0] data1;
    logic [WORD_LENGTH-1:0] data2;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [WORD_LENGTH-1:0] alu_out;
    logic                   busy;

    modport master (
        output req_valid, exec_fun, data1, data2, resp_ready,
        input  req_ready, resp_valid, alu_out, busy
    );

    modport slave (
        input  req_valid, exec_fun, data1, data2, resp_ready,
        output req_ready, resp_valid, alu_out, busy
    );
endinterface

// File: rtl/riscv_exec_unit.sv
// RV32I execute unit with valid/ready handshakes; the iterative M-extension
// multiply/divide datapath is built only when RISCV_EXEC_MDU_EN is defined.
module riscv_exec_unit #(
    parameter int unsigned WORD_LENGTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    riscv_exec_unit_if.slave  bus
);
    import riscv_constants_pkg::*;

    localparam int unsigned W  = WORD_LENGTH;
    localparam int unsigned SW = $clog2(WORD_LENGTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   alu_out_q, alu_out_d;
    logic [W-1:0]   a, b, alu_res;
    logic [SW-1:0]  shamt;

    assign a     = bus.data1;
    assign b     = bus.data2;
    assign shamt = b[SW-1:0];

    always_comb begin : single_cycle_alu
        alu_res = '0;
        case (bus.exec_fun)
            ALU_ADD:   alu_res = a + b;
            ALU_SUB:   alu_res = a - b;
            ALU_AND:   alu_res = a & b;
            ALU_OR:    alu_res = a | b;
            ALU_XOR:   alu_res = a ^ b;
            ALU_SLL:   alu_res = a << shamt;
            ALU_SRL:   alu_res = a >> shamt;
            ALU_SRA:   alu_res = $signed(a) >>> shamt;
            ALU_SLT:   alu_res = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU:  alu_res = {{(W-1){1'b0}}, a < b};
            ALU_COPY1: alu_res = a;
            default:   alu_res = '0;
        endcase
    end

`ifdef RISCV_EXEC_MDU_EN
    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   m_q, m_d;
    logic [SW-1:0]  cnt_q, cnt_d;
    logic           div_q, div_d, hi_q, hi_d, neg_q, neg_d;

    logic           is_mul, is_div, s1, s2, neg, hi, div_zero, div_ovf;
    logic [W-1:0]   a_mag, b_mag, bound_res;

    always_comb begin : mdu_decode
        is_mul    = bus.exec_fun inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
        is_div    = bus.exec_fun inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
        s1        = a[W-1] && (bus.exec_fun inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM});
        s2        = b[W-1] && (bus.exec_fun inside {ALU_MULH, ALU_DIV, ALU_REM});
        a_mag     = s1 ? -a : a;
        b_mag     = s2 ? -b : b;
        neg       = (bus.exec_fun == ALU_REM) ? s1 : (s1 ^ s2);
        hi        = bus.exec_fun inside {ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_REM, ALU_REMU};
        div_zero  = is_div && (b == '0);
        div_ovf   = (bus.exec_fun inside {ALU_DIV, ALU_REM}) &&
                    (a == {1'b1, {(W-1){1'b0}}}) && (b == '1);
        bound_res = '0;
        if (div_zero)
            bound_res = (bus.exec_fun inside {ALU_DIV, ALU_DIVU}) ? '1 : a;
        else if (div_ovf)
            bound_res = (bus.exec_fun == ALU_DIV) ? a : '0;
    end

    // acc_q holds {high, low} of the product, or {remainder, quotient} for divides,
    // so a single "hi" select picks MULH*/REM* results from the upper half.
    logic [W:0]     mul_sum, r_sh, r_diff;
    logic [2*W-1:0] step, prod_s;
    logic [W-1:0]   word, final_res;

    assign mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, m_q} : {(W+1){1'b0}});
    assign r_sh    = {acc_q[2*W-1:W], acc_q[W-1]};
    assign r_diff  = r_sh - {1'b0, m_q};

    always_comb begin : mdu_step
        if (div_q)
            step = r_diff[W] ? {r_sh[W-1:0], acc_q[W-2:0], 1'b0}
                             : {r_diff[W-1:0], acc_q[W-2:0], 1'b1};
        else
            step = {mul_sum, acc_q[W-1:1]};
        prod_s = neg_q ? -step : step;
        word   = hi_q ? step[2*W-1:W] : step[W-1:0];
        if (div_q)
            final_res = neg_q ? -word : word;
        else
            final_res = hi_q ? prod_s[2*W-1:W] : prod_s[W-1:0];
    end
`endif

    always_comb begin : fsm_next
        state_d   = state_q;
        alu_out_d = alu_out_q;
`ifdef RISCV_EXEC_MDU_EN
        acc_d     = acc_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        hi_d      = hi_q;
        neg_d     = neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d   = DONE;
                    alu_out_d = alu_res;
`ifdef RISCV_EXEC_MDU_EN
                    if (div_zero || div_ovf) begin
                        alu_out_d = bound_res;
                    end else if (is_mul || is_div) begin
                        state_d   = CALC;
                        alu_out_d = alu_out_q;
                        acc_d     = {{W{1'b0}}, (is_div ? a_mag : b_mag)};
                        m_d       = is_div ? b_mag : a_mag;
                        cnt_d     = '0;
                        div_d     = is_div;
                        hi_d      = hi;
                        neg_d     = neg;
                    end
`endif
                end
            end
`ifdef RISCV_EXEC_MDU_EN
            CALC: begin
                acc_d = step;
                cnt_d = cnt_q + SW'(1);
                if (cnt_q == SW'(W-1)) begin
                    alu_out_d = final_res;
                    state_d   = DONE;
                    cnt_d     = '0;
                end
            end
`endif
            DONE: begin
                if (bus.resp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            alu_out_q <= '0;
`ifdef RISCV_EXEC_MDU_EN
            acc_q     <= '0;
            m_q       <= '0;
            cnt_q     <= '0;
            div_q     <= 1'b0;
            hi_q      <= 1'b0;
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            alu_out_q <= alu_out_d;
`ifdef RISCV_EXEC_MDU_EN
            acc_q     <= acc_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            hi_q      <= hi_d;
            neg_q     <= neg_d;
`endif
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.resp_valid = (state_q == DONE);
    assign bus.alu_out    = alu_out_q;

endmodule

// File: tb/tb_riscv_exec_unit.sv
// Directed test of riscv_exec_unit at WORD_LENGTH = 32; multiply/divide expectations
// follow whether RISCV_EXEC_MDU_EN is defined for the build.
module tb_riscv_exec_unit;
    import riscv_constants_pkg::*;

`ifdef RISCV_EXEC_MDU_EN
    localparam bit MDU_ON  = 1'b1;
`else
    localparam bit MDU_ON  = 1'b0;
`endif
    localparam int MDU_LAT = MDU_ON ? 33 : 1;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    riscv_exec_unit_if #(.WORD_LENGTH(32)) bus ();

    riscv_exec_unit #(.WORD_LENGTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one request, measures cycles to resp_valid (accept cycle counts as 1),
    // optionally back-pressures, then completes the response handshake.
    task automatic run_op(input EXEC_FUN f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input int hold,
                          input string tag);
        int lat;
        bus.exec_fun  = f;
        bus.data1     = a;
        bus.data2     = b;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        lat           = 1;
        bus.req_valid = 1'b0;
        bus.data1     = $urandom;
        bus.data2     = $urandom;
        bus.exec_fun  = ALU_XOR;
        while (!bus.resp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check(tag, 64'(bus.alu_out), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_out"}, 64'(bus.alu_out), 64'(exp));
            check({tag, "_hold_rdy"}, 64'(bus.req_ready), 64'(0));
            check({tag, "_hold_vld"}, 64'(bus.resp_valid), 64'(1));
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        check({tag, "_idle"}, 64'(bus.req_ready), 64'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tests          = 0;
        fails          = 0;
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        bus.exec_fun   = ALU_ADD;
        bus.data1      = '0;
        bus.data2      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
        check("rst_alu_out",    64'(bus.alu_out),    64'(0));
        check("rst_busy",       64'(bus.busy),       64'(0));
        check("rst_req_ready",  64'(bus.req_ready),  64'(1));
        rst_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_idle_ready", 64'(bus.req_ready), 64'(1));
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(ALU_ADD,   32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1, 5, "add_wrap_bp");
        run_op(ALU_SRA,   32'h80000000, 32'h00000024, 32'hF8000000, 1, 0, "sra_mask");
        run_op(ALU_SUB,   32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1, 0, "sub_wrap");
        run_op(ALU_SLT,   32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1, 0, "slt");
        run_op(ALU_SLTU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, "sltu");
        run_op(ALU_SLL,   32'h00000001, 32'h00000021, 32'h00000002, 1, 0, "sll_mask");
        run_op(ALU_SRL,   32'h80000000, 32'h00000004, 32'h08000000, 1, 0, "srl");
        run_op(ALU_OR,    32'hF0F00000, 32'h0000F0F0, 32'hF0F0F0F0, 1, 0, "or");
        run_op(ALU_XOR,   32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1, 0, "xor");
        run_op(EXEC_FUN'(5'd31), 32'h12345678, 32'h1, 32'h00000000, 1, 0, "unknown");

        run_op(ALU_MULH,   32'hFFFFFFFD, 32'h00000005, MDU_ON ? 32'hFFFFFFFF : 32'h0, MDU_LAT, 0, "mulh");
        run_op(ALU_MUL,    32'hFFFFFFFD, 32'h00000005, MDU_ON ? 32'hFFFFFFF1 : 32'h0, MDU_LAT, 0, "mul");
        run_op(ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, MDU_ON ? 32'hFFFFFFFE : 32'h0, MDU_LAT, 0, "mulhu");
        run_op(ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, MDU_ON ? 32'hFFFFFFFF : 32'h0, MDU_LAT, 0, "mulhsu");
        run_op(ALU_DIV,    32'hFFFFFFF9, 32'h00000002, MDU_ON ? 32'hFFFFFFFD : 32'h0, MDU_LAT, 0, "div");
        run_op(ALU_REM,    32'hFFFFFFF9, 32'h00000002, MDU_ON ? 32'hFFFFFFFF : 32'h0, MDU_LAT, 0, "rem");
        run_op(ALU_DIVU,   32'h00000064, 32'h00000007, MDU_ON ? 32'h0000000E : 32'h0, MDU_LAT, 0, "divu");
        run_op(ALU_REMU,   32'h00000064, 32'h00000007, MDU_ON ? 32'h00000002 : 32'h0, MDU_LAT, 0, "remu");
        run_op(ALU_DIVU,   32'h0000007B, 32'h00000000, MDU_ON ? 32'hFFFFFFFF : 32'h0, 1, 0, "divu_by0");
        run_op(ALU_REMU,   32'h00000009, 32'h00000000, MDU_ON ? 32'h00000009 : 32'h0, 1, 0, "remu_by0");
        run_op(ALU_DIV,    32'h80000000, 32'hFFFFFFFF, MDU_ON ? 32'h80000000 : 32'h0, 1, 0, "div_ovf");
        run_op(ALU_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 0, "rem_ovf");

        run_op(ALU_COPY1, 32'h12345678, 32'h00000000, 32'h12345678, 1, 0, "copy1");
        bus.exec_fun  = ALU_DIVU;
        bus.data1     = 32'd1000;
        bus.data2     = 32'd3;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("calc_busy", 64'(bus.busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check("abort_resp_valid", 64'(bus.resp_valid), 64'(0));
        check("abort_alu_out",    64'(bus.alu_out),    64'(0));
        check("abort_busy",       64'(bus.busy),       64'(0));
        check("abort_req_ready",  64'(bus.req_ready),  64'(1));
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(ALU_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1, 0, "and_after_abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
